pomdp_episode_ctrl: RTL and testbench
=====================================

Name: pomdp_episode_ctrl

Overview:
- Sequencer for the POMDP one-step state/reward generator: runs one episode of `num_steps` transitions.
- Each step: requests an action from the policy block, supplies a fresh LFSR random word and the current state, fires the generator, and captures the new state and reward.
- Accumulates total episode reward with saturation. Reports done, abort or error.
- Sits between the policy/belief logic and the state generator in the step-4 simulation loop.

Parameters:
- `ACC_W`, 24, width of the episode reward accumulator (≥16).
- `STEP_W`, 8, width of the step counter and of `num_steps`.
- `TIMEOUT`, 15, max cycles spent in WAIT before a generator timeout error.
- `SEED_DFLT`, 16'hACE1, LFSR seed substituted when `seed` == 0.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin episode; sampled only in IDLE
- `abort`  in  1  terminate episode; effective from any non-IDLE state
- `num_steps`  in  STEP_W  steps per episode, latched at start; 0 = done immediately
- `init_state`  in  1  initial hidden state, latched at start
- `seed`  in  16  LFSR seed, latched at start
- `act_req`  out  1  request action from policy
- `act_valid`  in  1  policy action valid
- `act_in`  in  2  policy action; legal 0..2
- `gen_en`  out  1  one-cycle fire pulse to generator
- `gen_state`  out  1  current hidden state to generator
- `gen_action`  out  2  latched action to generator
- `gen_random`  out  16  current LFSR value to generator
- `gen_valid`  in  1  generator result valid (en_calculate)
- `gen_new_state`  in  1  generator next state
- `gen_reward`  in  16  generator reward, unsigned
- `busy`  out  1  high in any state except IDLE
- `step_cnt`  out  STEP_W  completed steps this episode
- `total_reward`  out  ACC_W  saturating reward sum
- `done`  out  1  one-cycle pulse, normal completion
- `aborted`  out  1  one-cycle pulse, abort taken
- `err`  out  2  sticky error code: 0 none, 1 illegal action, 2 generator timeout; cleared at next accepted start

Behaviour:
- Reset (`rst_n`=0 at a clk edge): FSM=IDLE. `act_req`, `gen_en`, `busy`, `done`, `aborted`=0. `step_cnt`=0, `total_reward`=0, `err`=0, `gen_state`=0, `gen_action`=0. LFSR=`SEED_DFLT`. Reset mid-episode discards everything.
- FSM states: IDLE, POLICY, FIRE, WAIT, UPDATE, FINISH.
- IDLE, `start`=1:
  - Latch `num_steps`, `init_state`→`gen_state`, and `seed` (or `SEED_DFLT` if `seed`==0) into the LFSR.
  - Clear `step_cnt`, `total_reward` and `err`.
  - Next state is FINISH if `num_steps`==0, else POLICY.
- POLICY: `act_req`=1.
  - On `act_valid`: if `act_in`==3, set `err`=1 and go to FINISH; else latch `act_in`→`gen_action` and go to FIRE.
- FIRE: `gen_en`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: counts cycles.
  - On `gen_valid`=1: capture `gen_new_state` and `gen_reward`, go to UPDATE.
  - If `TIMEOUT` cycles elapse without `gen_valid`: set `err`=2, go to FINISH.
  - `gen_valid` during FIRE or any non-WAIT state is ignored.
- UPDATE:
  - `gen_state`←captured new state.
  - `total_reward`←min(`total_reward`+reward, 2^ACC_W−1).
  - `step_cnt`++.
  - LFSR advances one step: Galois right shift, lfsr = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Go to FINISH if the new `step_cnt`==`num_steps`, else POLICY.
- FINISH: `done`=1 for one cycle (also on error exits, with `err` indicating cause). Go to IDLE.
- Timing: with `act_valid` held high and `gen_valid` arriving the cycle after `gen_en`, a step takes 4 cycles (POLICY, FIRE, WAIT, UPDATE).
- `abort`: checked before every other transition in any non-IDLE state.
  - Next cycle is IDLE with `aborted`=1 for one cycle; `done` is not pulsed.
  - `step_cnt` and `total_reward` hold their values.
  - `abort` in IDLE is ignored. `abort` and `start` together in IDLE: `start` is taken.
- `start` while `busy` is ignored.
- `gen_random`, `gen_state` and `gen_action` are registered, stable from FIRE through WAIT.
- `step_cnt` never wraps: `num_steps` ≤ 2^STEP_W−1 bounds it.

Test Plan:
- Reset, then `start` with `seed`=16'h0001, `num_steps`=1, `init_state`=0, `act_in`=1, generator returns state 1, reward 16'h0010 one cycle after `gen_en` → `gen_random`=16'h0001 at FIRE; `done` pulses 5 cycles after `start`; `total_reward`=16, `step_cnt`=1, `err`=0; LFSR afterwards = 16'hB400.
- `num_steps`=4, reward 16'hFFFF each step, `ACC_W`=17 → `total_reward` saturates at 17'h1FFFF; `step_cnt`=4; exactly 4 `gen_en` pulses.
- `act_in`=3 on the first request → `err`=1, no `gen_en`, `done` pulse, `step_cnt`=0; next `start` clears `err`.
- Generator never asserts `gen_valid` → `err`=2 and `done` exactly `TIMEOUT` cycles after WAIT entry; further `gen_valid` is ignored.
- `abort` during WAIT of step 2 of 3 → `aborted` pulse, `step_cnt`=1, no `done`; `start` during the busy period is ignored.
- `seed`=0 → first `gen_random`=16'hACE1; `num_steps`=0 → `done` one cycle after `start` with no `act_req`.

Source files
------------

// File: rtl/pomdp_episode_ctrl.sv
// Episode sequencer for the POMDP one-step generator. Each step goes policy -> fire -> wait -> update.
// A run lasts num_steps steps and sums the rewards into a saturating accumulator.
module pomdp_episode_ctrl #(
    parameter int          ACC_W     = 24,
    parameter int          STEP_W    = 8,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] SEED_DFLT = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              init_state,
    input  logic [15:0]       seed,
    output logic              act_req,
    input  logic              act_valid,
    input  logic [1:0]        act_in,
    output logic              gen_en,
    output logic              gen_state,
    output logic [1:0]        gen_action,
    output logic [15:0]       gen_random,
    input  logic              gen_valid,
    input  logic              gen_new_state,
    input  logic [15:0]       gen_reward,
    output logic              busy,
    output logic [STEP_W-1:0] step_cnt,
    output logic [ACC_W-1:0]  total_reward,
    output logic              done,
    output logic              aborted,
    output logic [1:0]        err
);
    // The timeout counter only needs to reach TIMEOUT-1.
    localparam int                TMO_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [1:0]        ERR_NONE    = 2'd0;
    localparam logic [1:0]        ERR_ACTION  = 2'd1;
    localparam logic [1:0]        ERR_TIMEOUT = 2'd2;
    localparam logic [15:0]       LFSR_TAPS   = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLICY,
        S_FIRE,
        S_WAIT,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t             state_reg, state_next;
    logic [STEP_W-1:0]  num_steps_reg, num_steps_next;
    logic               gen_state_reg, gen_state_next;
    logic [1:0]         gen_action_reg, gen_action_next;
    logic [15:0]        lfsr_reg, lfsr_next;
    logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;
    logic [ACC_W-1:0]   total_reg, total_next;
    logic [1:0]         err_reg, err_next;
    logic               aborted_reg, aborted_next;
    logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic               cap_state_reg, cap_state_next;
    logic [15:0]        cap_reward_reg, cap_reward_next;

    logic [ACC_W:0]     reward_sum;
    logic [ACC_W-1:0]   reward_sat;
    logic [15:0]        lfsr_adv;
    logic [STEP_W-1:0]  step_inc;

    // One extra bit on the sum exposes the overflow that triggers saturation.
    assign reward_sum = {1'b0, total_reg} + {{(ACC_W + 1 - 16){1'b0}}, cap_reward_reg};
    assign reward_sat = reward_sum[ACC_W] ? {ACC_W{1'b1}} : reward_sum[ACC_W-1:0];
    assign lfsr_adv   = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    assign step_inc   = step_cnt_reg + STEP_W'(1);

    always_comb begin
        state_next      = state_reg;
        num_steps_next  = num_steps_reg;
        gen_state_next  = gen_state_reg;
        gen_action_next = gen_action_reg;
        lfsr_next       = lfsr_reg;
        step_cnt_next   = step_cnt_reg;
        total_next      = total_reg;
        err_next        = err_reg;
        aborted_next    = 1'b0;
        tmo_cnt_next    = tmo_cnt_reg;
        cap_state_next  = cap_state_reg;
        cap_reward_next = cap_reward_reg;

        act_req = (state_reg == S_POLICY);
        gen_en  = (state_reg == S_FIRE);
        busy    = (state_reg != S_IDLE);
        done    = (state_reg == S_FINISH);

        // Abort takes priority over every other transition and freezes the datapath.
        if (abort && state_reg != S_IDLE) begin
            state_next   = S_IDLE;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_steps_next = num_steps;
                        gen_state_next = init_state;
                        lfsr_next      = (seed == 16'h0000) ? SEED_DFLT : seed;
                        step_cnt_next  = '0;
                        total_next     = '0;
                        err_next       = ERR_NONE;
                        state_next     = (num_steps == '0) ? S_FINISH : S_POLICY;
                    end
                end
                S_POLICY: begin
                    if (act_valid) begin
                        if (act_in == 2'd3) begin
                            err_next   = ERR_ACTION;
                            state_next = S_FINISH;
                        end else begin
                            gen_action_next = act_in;
                            state_next      = S_FIRE;
                        end
                    end
                end
                S_FIRE: begin
                    tmo_cnt_next = '0;
                    state_next   = S_WAIT;
                end
                S_WAIT: begin
                    if (gen_valid) begin
                        cap_state_next  = gen_new_state;
                        cap_reward_next = gen_reward;
                        state_next      = S_UPDATE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        err_next   = ERR_TIMEOUT;
                        state_next = S_FINISH;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
                S_UPDATE: begin
                    gen_state_next = cap_state_reg;
                    total_next     = reward_sat;
                    step_cnt_next  = step_inc;
                    lfsr_next      = lfsr_adv;
                    state_next     = (step_inc == num_steps_reg) ? S_FINISH : S_POLICY;
                end
                S_FINISH: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            num_steps_reg  <= '0;
            gen_state_reg  <= 1'b0;
            gen_action_reg <= 2'd0;
            lfsr_reg       <= SEED_DFLT;
            step_cnt_reg   <= '0;
            total_reg      <= '0;
            err_reg        <= ERR_NONE;
            aborted_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
            cap_state_reg  <= 1'b0;
            cap_reward_reg <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            num_steps_reg  <= num_steps_next;
            gen_state_reg  <= gen_state_next;
            gen_action_reg <= gen_action_next;
            lfsr_reg       <= lfsr_next;
            step_cnt_reg   <= step_cnt_next;
            total_reg      <= total_next;
            err_reg        <= err_next;
            aborted_reg    <= aborted_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            cap_state_reg  <= cap_state_next;
            cap_reward_reg <= cap_reward_next;
        end
    end

    assign gen_state    = gen_state_reg;
    assign gen_action   = gen_action_reg;
    assign gen_random   = lfsr_reg;
    assign step_cnt     = step_cnt_reg;
    assign total_reward = total_reg;
    assign err          = err_reg;
    assign aborted      = aborted_reg;

endmodule

// File: tb/tb_pomdp_episode_ctrl.sv
// Randomised bench for pomdp_episode_ctrl. It compares each episode against a step-level model of timing,
// saturating reward, LFSR sequence, errors and abort.
module tb_pomdp_episode_ctrl;
    localparam int     ACC_W   = 17;
    localparam int     STEP_W  = 8;
    localparam int     TIMEOUT = 15;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, init_state, act_req, act_valid, gen_en, gen_state;
    logic [STEP_W-1:0] num_steps, step_cnt;
    logic [15:0]       seed, gen_random, gen_reward;
    logic [1:0]        act_in, gen_action, err;
    logic              gen_valid, gen_new_state, busy, done, aborted;
    logic [ACC_W-1:0]  total_reward;

    always #5 clk = ~clk;

    pomdp_episode_ctrl #(
        .ACC_W(ACC_W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT), .SEED_DFLT(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_steps(num_steps),
        .init_state(init_state), .seed(seed), .act_req(act_req), .act_valid(act_valid),
        .act_in(act_in), .gen_en(gen_en), .gen_state(gen_state), .gen_action(gen_action),
        .gen_random(gen_random), .gen_valid(gen_valid), .gen_new_state(gen_new_state),
        .gen_reward(gen_reward), .busy(busy), .step_cnt(step_cnt), .total_reward(total_reward),
        .done(done), .aborted(aborted), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-step stimulus: policy action, generator next state and reward.
    int          act_tab [64];
    logic        ns_tab  [64];
    logic [15:0] rew_tab [64];

    // Observed episode.
    int               o_end_cyc, o_fires, o_act_req_cnt;
    bit               o_done, o_aborted;
    logic [15:0]      o_rand [64];
    logic             o_gstate [64];
    logic [1:0]       o_gact [64];
    logic [STEP_W-1:0] o_steps, o_steps_after;
    logic [ACC_W-1:0] o_total;
    logic [1:0]       o_err, o_err_after;
    logic [15:0]      o_lfsr_after;
    logic             o_busy_after, o_gstate_after;

    // Expected episode.
    int               e_end, e_fires, e_steps;
    bit               e_aborted;
    logic [1:0]       e_err;
    logic [15:0]      e_rand [64];
    logic             e_gstate [64];
    logic [1:0]       e_gact [64];
    logic [ACC_W-1:0] e_total;
    logic [15:0]      e_lfsr;
    logic             e_state_end;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Step-level model. It assumes act_valid is held high and a one-cycle generator latency.
    // Cycle 0 is the start cycle and step k begins its policy request at cycle 4k+1.
    task automatic compute_expected(input int n, input logic init_s, input logic [15:0] sd,
                                    input int a, input int gen_mode);
        logic [15:0] lf;
        logic        st;
        longint      tot;
        bit          fin;
        int          pol, f;
        lf = (sd == 16'h0000) ? 16'hACE1 : sd;
        st = init_s; tot = 0; fin = 0;
        e_steps = 0; e_fires = 0; e_err = 2'd0; e_aborted = 0; e_end = 1;
        for (int k = 0; k < n && !fin; k++) begin
            pol = 4 * k + 1;
            f   = pol + 1;
            if (a >= 0 && a <= pol) begin
                e_aborted = 1; e_end = a + 1; fin = 1;
            end else if (act_tab[k] == 3) begin
                e_err = 2'd1; e_end = pol + 1; fin = 1;
            end else begin
                e_rand[k] = lf; e_gstate[k] = st; e_gact[k] = act_tab[k][1:0];
                e_fires++;
                if (a == f) begin
                    e_aborted = 1; e_end = a + 1; fin = 1;
                end else if (gen_mode == 1) begin
                    if (a >= 0 && a <= f + TIMEOUT) begin
                        e_aborted = 1; e_end = a + 1;
                    end else begin
                        e_err = 2'd2; e_end = f + TIMEOUT + 1;
                    end
                    fin = 1;
                end else if (a >= 0 && a <= f + 2) begin
                    e_aborted = 1; e_end = a + 1; fin = 1;
                end else begin
                    tot = tot + longint'(rew_tab[k]);
                    if (tot > ACC_MAX) tot = ACC_MAX;
                    st = ns_tab[k];
                    e_steps++;
                    lf = lfsr_step(lf);
                    e_end = f + 3;
                end
            end
        end
        e_total = tot[ACC_W-1:0];
        e_lfsr = lf;
        e_state_end = st;
    endtask

    // Drives one episode cycle by cycle, acting as policy and generator. Records what the DUT shows.
    // gen_mode 0: valid one cycle after gen_en. gen_mode 1: valid only outside WAIT (never accepted).
    task automatic run_episode(input int n, input logic init_s, input logic [15:0] sd,
                               input int abort_cyc, input int gen_mode, input int busy_start_cyc);
        int fire_cyc;
        bit fin;
        int limit;
        fire_cyc = -100; fin = 0; limit = 4 * n + TIMEOUT + 20;
        o_fires = 0; o_done = 0; o_aborted = 0; o_act_req_cnt = 0; o_end_cyc = -1;
        @(negedge clk);
        start = 1'b1; num_steps = STEP_W'(n); init_state = init_s; seed = sd;
        abort = 1'b0; gen_valid = 1'b0; act_valid = 1'b1; act_in = 2'd0;
        for (int c = 1; c <= limit && !fin; c++) begin
            @(negedge clk);
            start = (c == busy_start_cyc);
            if (start) begin
                num_steps = 8'd1; seed = 16'h1234; init_state = ~init_s;
            end
            abort = (c == abort_cyc);
            gen_valid = 1'b0;
            if (gen_en) begin
                o_rand[o_fires] = gen_random;
                o_gstate[o_fires] = gen_state;
                o_gact[o_fires] = gen_action;
                o_fires++;
                fire_cyc = c;
                if (gen_mode == 1) begin
                    gen_valid = 1'b1; gen_new_state = 1'b1; gen_reward = 16'h5555;
                end
            end
            if (gen_mode == 0 && c == fire_cyc + 1) begin
                gen_valid = 1'b1;
                gen_new_state = ns_tab[o_fires-1];
                gen_reward = rew_tab[o_fires-1];
            end
            if (act_req) begin
                o_act_req_cnt++;
                act_in = act_tab[o_fires][1:0];
            end
            if (done || aborted) begin
                o_done = done; o_aborted = aborted; o_end_cyc = c;
                o_steps = step_cnt; o_total = total_reward; o_err = err;
                fin = 1;
                if (gen_mode == 1) begin
                    gen_valid = 1'b1; gen_new_state = 1'b1; gen_reward = 16'h7777;
                end
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (!fin) begin
            n_checks++; n_fail++;
            $display("FAIL episode_bound: no done/aborted within %0d cycles", limit);
        end
        @(negedge clk);
        gen_valid = 1'b0;
        o_lfsr_after = gen_random; o_busy_after = busy; o_err_after = err;
        o_steps_after = step_cnt; o_gstate_after = gen_state;
    endtask

    task automatic fill_tables(input int act, input logic [15:0] rew);
        for (int k = 0; k < 64; k++) begin
            act_tab[k] = act;
            ns_tab[k]  = 1'($urandom);
            rew_tab[k] = rew;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_steps = '0; init_state = 1'b0; seed = 16'h0;
        act_valid = 1'b0; act_in = 2'd0; gen_valid = 1'b0; gen_new_state = 1'b0; gen_reward = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, act_req, gen_en, done, aborted} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, act_req, gen_en, done, aborted});
        end
        n_checks++;
        if ({step_cnt, total_reward, err} !== '0) begin
            n_fail++; $display("FAIL reset_counts: step %0d total %0d err %0d expected 0", step_cnt, total_reward, err);
        end
        n_checks++;
        if ({gen_state, gen_action, gen_random} !== {1'b0, 2'd0, 16'hACE1}) begin
            n_fail++; $display("FAIL reset_gen: state %b action %0d random %h expected 0 0 ace1", gen_state, gen_action, gen_random);
        end
        rst_n = 1'b1;
        // Reset in the middle of an episode whose generator never answers.
        @(negedge clk);
        start = 1'b1; num_steps = 8'd5; seed = 16'h0F0F; init_state = 1'b1; act_valid = 1'b1; act_in = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({busy, gen_state, gen_action, gen_random} !== {1'b0, 1'b0, 2'd0, 16'hACE1}) begin
            n_fail++; $display("FAIL midreset_state: busy %b gstate %b gact %0d rand %h expected 0 0 0 ace1", busy, gen_state, gen_action, gen_random);
        end
    endtask

    task automatic test_single_step;
        fill_tables(1, 16'h0010);
        ns_tab[0] = 1'b1;
        run_episode(1, 1'b0, 16'h0001, -1, 0, -1);
        n_checks++;
        if (o_rand[0] !== 16'h0001) begin n_fail++; $display("FAIL single_random: got %h expected 0001", o_rand[0]); end
        n_checks++;
        if (o_end_cyc != 5 || !o_done) begin n_fail++; $display("FAIL single_done_cycle: got %0d (done %0d) expected 5", o_end_cyc, o_done); end
        n_checks++;
        if (o_total !== 17'd16 || o_steps !== 8'd1 || o_err !== 2'd0) begin
            n_fail++; $display("FAIL single_result: total %0d step %0d err %0d expected 16 1 0", o_total, o_steps, o_err);
        end
        n_checks++;
        if (o_lfsr_after !== 16'hB400) begin n_fail++; $display("FAIL single_lfsr: got %h expected b400", o_lfsr_after); end
        n_checks++;
        if (o_gact[0] !== 2'd1 || o_gstate[0] !== 1'b0 || o_gstate_after !== 1'b1) begin
            n_fail++; $display("FAIL single_gen_regs: act %0d state %b new %b expected 1 0 1", o_gact[0], o_gstate[0], o_gstate_after);
        end
    endtask

    task automatic test_saturation;
        fill_tables(0, 16'hFFFF);
        for (int k = 0; k < 4; k++) act_tab[k] = int'($urandom_range(0, 2));
        run_episode(4, 1'b1, 16'h3C5A, -1, 0, -1);
        n_checks++;
        if (o_total !== 17'h1FFFF) begin n_fail++; $display("FAIL sat_total: got %h expected 1ffff", o_total); end
        n_checks++;
        if (o_steps !== 8'd4 || o_fires != 4 || o_end_cyc != 17) begin
            n_fail++; $display("FAIL sat_steps: step %0d fires %0d done_cyc %0d expected 4 4 17", o_steps, o_fires, o_end_cyc);
        end
    endtask

    task automatic test_illegal_action;
        fill_tables(3, 16'h0100);
        run_episode(3, 1'b0, 16'h00FF, -1, 0, -1);
        n_checks++;
        if (o_err !== 2'd1 || o_fires != 0 || !o_done || o_steps !== 8'd0 || o_end_cyc != 2) begin
            n_fail++; $display("FAIL illegal_action: err %0d fires %0d done %0d step %0d cyc %0d expected 1 0 1 0 2", o_err, o_fires, o_done, o_steps, o_end_cyc);
        end
        fill_tables(2, 16'h0100);
        run_episode(1, 1'b0, 16'h00FF, -1, 0, -1);
        n_checks++;
        if (o_err !== 2'd0 || o_total !== 17'h00100) begin
            n_fail++; $display("FAIL illegal_cleared: err %0d total %h expected 0 00100", o_err, o_total);
        end
    endtask

    task automatic test_timeout;
        fill_tables(0, 16'h0042);
        run_episode(2, 1'b1, 16'hBEEF, -1, 1, -1);
        n_checks++;
        if (o_err !== 2'd2 || !o_done || o_end_cyc != 3 + TIMEOUT) begin
            n_fail++; $display("FAIL timeout_err: err %0d done %0d cyc %0d expected 2 1 %0d", o_err, o_done, o_end_cyc, 3 + TIMEOUT);
        end
        n_checks++;
        if (o_fires != 1 || o_steps_after !== 8'd0 || o_err_after !== 2'd2 || o_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: fires %0d step %0d err %0d busy %b expected 1 0 2 0", o_fires, o_steps_after, o_err_after, o_busy_after);
        end
    endtask

    task automatic test_abort;
        fill_tables(1, 16'h0000);
        rew_tab[0] = 16'h0123; rew_tab[1] = 16'h0456;
        run_episode(3, 1'b0, 16'h1111, 7, 0, 3);
        n_checks++;
        if (!o_aborted || o_done || o_end_cyc != 8) begin
            n_fail++; $display("FAIL abort_pulse: aborted %0d done %0d cyc %0d expected 1 0 8", o_aborted, o_done, o_end_cyc);
        end
        n_checks++;
        if (o_steps !== 8'd1 || o_total !== 17'h00123 || o_fires != 2 || o_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL abort_hold: step %0d total %h fires %0d busy %b expected 1 00123 2 0", o_steps, o_total, o_fires, o_busy_after);
        end
    endtask

    task automatic test_seed_zero_and_empty;
        fill_tables(0, 16'h0001);
        run_episode(2, 1'b0, 16'h0000, -1, 0, -1);
        n_checks++;
        if (o_rand[0] !== 16'hACE1) begin n_fail++; $display("FAIL seed_zero: got %h expected ace1", o_rand[0]); end
        run_episode(0, 1'b1, 16'h4321, -1, 0, -1);
        n_checks++;
        if (o_end_cyc != 1 || !o_done || o_act_req_cnt != 0 || o_fires != 0) begin
            n_fail++; $display("FAIL empty_episode: cyc %0d done %0d act_req %0d fires %0d expected 1 1 0 0", o_end_cyc, o_done, o_act_req_cnt, o_fires);
        end
    endtask

    // Back-to-back random episodes with occasional illegal actions, zero seeds and aborts.
    task automatic test_random_episodes;
        int          n, a;
        logic        init_s;
        logic [15:0] sd;
        for (int it = 0; it < 30; it++) begin
            n = int'($urandom_range(1, 6));
            init_s = 1'($urandom);
            sd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            for (int k = 0; k < 64; k++) begin
                act_tab[k] = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
                ns_tab[k]  = 1'($urandom);
                rew_tab[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            compute_expected(n, init_s, sd, -1, 0);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, e_end - 1)) : -1;
            compute_expected(n, init_s, sd, a, 0);
            run_episode(n, init_s, sd, a, 0, -1);
            n_checks++;
            if (o_end_cyc != e_end || o_aborted != e_aborted || o_done == e_aborted) begin
                n_fail++; $display("FAIL rand%0d_end: cyc %0d aborted %0d done %0d expected cyc %0d aborted %0d", it, o_end_cyc, o_aborted, o_done, e_end, e_aborted);
            end
            n_checks++;
            if (o_steps !== 8'(e_steps) || o_total !== e_total || o_err !== e_err) begin
                n_fail++; $display("FAIL rand%0d_result: step %0d total %h err %0d expected %0d %h %0d", it, o_steps, o_total, o_err, e_steps, e_total, e_err);
            end
            n_checks++;
            if (o_fires != e_fires || o_lfsr_after !== e_lfsr) begin
                n_fail++; $display("FAIL rand%0d_fires_lfsr: fires %0d lfsr %h expected %0d %h", it, o_fires, o_lfsr_after, e_fires, e_lfsr);
            end
            for (int k = 0; k < e_fires && k < o_fires; k++) begin
                n_checks++;
                if ({o_rand[k], o_gstate[k], o_gact[k]} !== {e_rand[k], e_gstate[k], e_gact[k]}) begin
                    n_fail++; $display("FAIL rand%0d_fire%0d: rand %h state %b act %0d expected %h %b %0d", it, k, o_rand[k], o_gstate[k], o_gact[k], e_rand[k], e_gstate[k], e_gact[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_step;
        test_saturation;
        test_illegal_action;
        test_timeout;
        test_abort;
        test_seed_zero_and_empty;
        test_random_episodes;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
